// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline controller.
// State encodings, default widths and the performance counter width.
package pipe_ctrl_pkg;

  localparam int unsigned DefaultPcW    = 64;
  localparam int unsigned DefaultRaW    = 5;
  localparam int unsigned DefaultOutstW = 2;
  localparam int unsigned PerfCntW      = 32;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StRedir = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Load-use comparator: flags an ID instruction that reads the destination
// of a load currently in EXE. Purely combinational.
module pipe_ctrl_hazard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RA_W = DefaultRaW
) (
  input  logic            exe_valid,
  input  logic            exe_is_load,
  input  logic [RA_W-1:0] exe_rd,
  input  logic            id_rs1_ren,
  input  logic            id_rs2_ren,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  output logic            hazard
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = id_rs1_ren && (id_rs1 == exe_rd);
    rs2_hit = id_rs2_ren && (id_rs2 == exe_rd);
    // x0 is never written, so it can never be a hazard source
    hazard  = exe_valid && exe_is_load && (exe_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: allow-in chain, flushes, load-use stall and
// PC redirect sequencing. Optional PIPE_CTRL_PERF_EN adds stall/redirect counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned PC_W    = DefaultPcW,
  parameter int unsigned OUTST_W = DefaultOutstW,
  parameter int unsigned RA_W    = DefaultRaW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic                exe_valid,
  input  logic                mem_valid,
  input  logic                if_ready_go,
  input  logic                exe_ready_go,
  input  logic                mem_ready_go,
  input  logic                id_rs1_ren,
  input  logic                id_rs2_ren,
  input  logic [RA_W-1:0]     id_rs1,
  input  logic [RA_W-1:0]     id_rs2,
  input  logic                exe_is_load,
  input  logic [RA_W-1:0]     exe_rd,
  input  logic                br_req,
  input  logic [PC_W-1:0]     br_target,
  input  logic                trap_req,
  input  logic [PC_W-1:0]     trap_target,
  input  logic                if_req_fire,
  input  logic                if_resp_fire,
  output logic                if_allow_in,
  output logic                id_allow_in,
  output logic                exe_allow_in,
  output logic                mem_allow_in,
  output logic                flush_if_id,
  output logic                flush_id_exe,
  output logic                flush_exe_mem,
  output logic                fetch_en,
  output logic                resp_discard,
  output logic                redirect_valid,
  output logic [PC_W-1:0]     redirect_pc
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PerfCntW-1:0] perf_hazard,
  output logic [PerfCntW-1:0] perf_mem,
  output logic [PerfCntW-1:0] perf_redirect
`endif
);

  localparam logic [OUTST_W-1:0] OutstMax = '1;

  pc_state_e          state_q, state_d;
  logic [PC_W-1:0]    tgt_q, tgt_d;
  logic [OUTST_W-1:0] outst_q, outst_d;
  logic [OUTST_W-1:0] stale_q, stale_d;

  logic hazard;
  logic id_ready_go;
  logic trap_take;
  logic br_take;
  logic flush_if_id_raw, flush_id_exe_raw, flush_exe_mem_raw;
  logic redirect_raw;

  pipe_ctrl_hazard #(
    .RA_W (RA_W)
  ) u_hazard (
    .exe_valid   (exe_valid),
    .exe_is_load (exe_is_load),
    .exe_rd      (exe_rd),
    .id_rs1_ren  (id_rs1_ren),
    .id_rs2_ren  (id_rs2_ren),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hazard      (hazard)
  );

  assign id_ready_go = !hazard;

  always_comb begin
    mem_allow_in = !mem_valid || mem_ready_go;
    exe_allow_in = !exe_valid || (exe_ready_go && mem_allow_in);
    id_allow_in  = !id_valid || (id_ready_go && exe_allow_in);
    if_allow_in  = if_ready_go && id_allow_in && (state_q == StRun);
  end

  // Traps are honoured while draining too; branches only from RUN
  always_comb begin
    trap_take = trap_req && mem_valid && ((state_q == StRun) || (state_q == StDrain));
    br_take   = br_req && exe_valid && (state_q == StRun) && !trap_take;
  end

  always_comb begin
    outst_d = outst_q;
    if (if_req_fire && !if_resp_fire) begin
      if (outst_q != OutstMax) outst_d = outst_q + 1'b1;
    end else if (!if_req_fire && if_resp_fire) begin
      if (outst_q != '0) outst_d = outst_q - 1'b1;
    end
  end

  always_comb begin
    state_d           = state_q;
    tgt_d             = tgt_q;
    flush_if_id_raw   = 1'b0;
    flush_id_exe_raw  = 1'b0;
    flush_exe_mem_raw = 1'b0;
    redirect_raw      = 1'b0;

    unique case (state_q)
      StRun: begin
        if (trap_take) begin
          flush_if_id_raw   = 1'b1;
          flush_id_exe_raw  = 1'b1;
          flush_exe_mem_raw = 1'b1;
          tgt_d             = trap_target;
          state_d           = StDrain;
        end else if (br_take) begin
          flush_if_id_raw  = 1'b1;
          flush_id_exe_raw = 1'b1;
          tgt_d            = br_target;
          state_d          = StDrain;
        end
      end
      StDrain: begin
        if (trap_take) begin
          flush_if_id_raw   = 1'b1;
          flush_id_exe_raw  = 1'b1;
          flush_exe_mem_raw = 1'b1;
          tgt_d             = trap_target;
        end
        // Leave as soon as the last in-flight response is consumed this cycle
        if (outst_d == '0) state_d = StRedir;
      end
      StRedir: begin
        redirect_raw = 1'b1;
        state_d      = StRun;
      end
      default: state_d = StRun;
    endcase

    if (hazard && exe_allow_in) flush_id_exe_raw = 1'b1;
  end

  always_comb begin
    stale_d = stale_q;
    if ((state_q == StRun) && (state_d == StDrain)) begin
      stale_d = outst_d;
    end else if (if_resp_fire && (stale_q != '0)) begin
      stale_d = stale_q - 1'b1;
    end
  end

  always_comb begin
    flush_if_id    = !rst && flush_if_id_raw;
    flush_id_exe   = !rst && flush_id_exe_raw;
    flush_exe_mem  = !rst && flush_exe_mem_raw;
    redirect_valid = !rst && redirect_raw;
    redirect_pc    = tgt_q;
    fetch_en       = !rst && (state_q == StRun) && (outst_q != OutstMax);
    resp_discard   = !rst && if_resp_fire && ((state_q == StDrain) || (stale_q != '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      tgt_q   <= '0;
      outst_q <= '0;
      stale_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      outst_q <= outst_d;
      stale_q <= stale_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PerfCntW-1:0] stall_hazard_cnt;
  logic [PerfCntW-1:0] stall_mem_cnt;
  logic [PerfCntW-1:0] redirect_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_hazard_cnt <= '0;
      stall_mem_cnt    <= '0;
      redirect_cnt     <= '0;
    end else begin
      if (hazard && (stall_hazard_cnt != '1)) stall_hazard_cnt <= stall_hazard_cnt + 1'b1;
      if (mem_valid && !mem_ready_go && (stall_mem_cnt != '1)) begin
        stall_mem_cnt <= stall_mem_cnt + 1'b1;
      end
      if (redirect_raw && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

  assign perf_hazard   = stall_hazard_cnt;
  assign perf_mem      = stall_mem_cnt;
  assign perf_redirect = redirect_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: allow-in, load-use, flush priority, drain/redirect,
// outstanding-fetch limit and mid-drain reset. Build with PIPE_CTRL_PERF_EN for counters.
module tb_pipe_ctrl;

  localparam int unsigned PC_W = 64;
  localparam int unsigned RA_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, exe_valid, mem_valid;
  logic            if_ready_go, exe_ready_go, mem_ready_go;
  logic            id_rs1_ren, id_rs2_ren;
  logic [RA_W-1:0] id_rs1, id_rs2;
  logic            exe_is_load;
  logic [RA_W-1:0] exe_rd;
  logic            br_req, trap_req;
  logic [PC_W-1:0] br_target, trap_target;
  logic            if_req_fire, if_resp_fire;
  logic            if_allow_in, id_allow_in, exe_allow_in, mem_allow_in;
  logic            flush_if_id, flush_id_exe, flush_exe_mem;
  logic            fetch_en, resp_discard, redirect_valid;
  logic [PC_W-1:0] redirect_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]     perf_hazard, perf_mem, perf_redirect;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .PC_W    (PC_W),
    .OUTST_W (2),
    .RA_W    (RA_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .exe_valid      (exe_valid),
    .mem_valid      (mem_valid),
    .if_ready_go    (if_ready_go),
    .exe_ready_go   (exe_ready_go),
    .mem_ready_go   (mem_ready_go),
    .id_rs1_ren     (id_rs1_ren),
    .id_rs2_ren     (id_rs2_ren),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .exe_is_load    (exe_is_load),
    .exe_rd         (exe_rd),
    .br_req         (br_req),
    .br_target      (br_target),
    .trap_req       (trap_req),
    .trap_target    (trap_target),
    .if_req_fire    (if_req_fire),
    .if_resp_fire   (if_resp_fire),
    .if_allow_in    (if_allow_in),
    .id_allow_in    (id_allow_in),
    .exe_allow_in   (exe_allow_in),
    .mem_allow_in   (mem_allow_in),
    .flush_if_id    (flush_if_id),
    .flush_id_exe   (flush_id_exe),
    .flush_exe_mem  (flush_exe_mem),
    .fetch_en       (fetch_en),
    .resp_discard   (resp_discard),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_hazard    (perf_hazard),
    .perf_mem       (perf_mem),
    .perf_redirect  (perf_redirect)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    exe_valid    = 1'b0;
    mem_valid    = 1'b0;
    if_ready_go  = 1'b1;
    exe_ready_go = 1'b1;
    mem_ready_go = 1'b1;
    id_rs1_ren   = 1'b0;
    id_rs2_ren   = 1'b0;
    id_rs1       = '0;
    id_rs2       = '0;
    exe_is_load  = 1'b0;
    exe_rd       = '0;
    br_req       = 1'b0;
    trap_req     = 1'b0;
    br_target    = '0;
    trap_target  = '0;
    if_req_fire  = 1'b0;
    if_resp_fire = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    // Requests during reset must not produce any control pulses
    mem_valid = 1'b1; trap_req = 1'b1; exe_valid = 1'b1; br_req = 1'b1; if_resp_fire = 1'b1;
    #1;
    check("rst_flush_if_id", flush_if_id, 0);
    check("rst_flush_exe_mem", flush_exe_mem, 0);
    check("rst_fetch_en", fetch_en, 0);
    check("rst_resp_discard", resp_discard, 0);
    check("rst_redirect", redirect_valid, 0);

    @(negedge clk); idle(); rst = 1'b0; #1;
    check("init_fetch_en", fetch_en, 1);
    check("init_if_allow", if_allow_in, 1);
    check("init_redirect_pc", redirect_pc, 0);

    // Load x5 in EXE, ID reads x5 via rs2
    @(negedge clk); idle();
    exe_valid = 1; exe_is_load = 1; exe_rd = 5;
    id_valid = 1; id_rs2_ren = 1; id_rs2 = 5; id_rs1_ren = 1; id_rs1 = 3; #1;
    check("lu_id_allow", id_allow_in, 0);
    check("lu_flush_id_exe", flush_id_exe, 1);
    check("lu_flush_if_id", flush_if_id, 0);
    check("lu_if_allow", if_allow_in, 0);
    check("lu_exe_allow", exe_allow_in, 1);

    // ID reads x0 while EXE loads x0: no stall
    @(negedge clk); idle();
    exe_valid = 1; exe_is_load = 1; exe_rd = 0;
    id_valid = 1; id_rs1_ren = 1; id_rs1 = 0; id_rs2_ren = 1; id_rs2 = 0; #1;
    check("x0_id_allow", id_allow_in, 1);
    check("x0_flush_id_exe", flush_id_exe, 0);

    // Matching rs2 but read-enable low: no stall
    @(negedge clk); idle();
    exe_valid = 1; exe_is_load = 1; exe_rd = 5;
    id_valid = 1; id_rs2_ren = 0; id_rs2 = 5; #1;
    check("noren_id_allow", id_allow_in, 1);

    // MEM stalled: hazard present but no bubble because EXE cannot accept
    @(negedge clk); idle();
    mem_valid = 1; mem_ready_go = 0;
    exe_valid = 1; exe_is_load = 1; exe_rd = 7;
    id_valid = 1; id_rs1_ren = 1; id_rs1 = 7; #1;
    check("bp_mem_allow", mem_allow_in, 0);
    check("bp_exe_allow", exe_allow_in, 0);
    check("bp_id_allow", id_allow_in, 0);
    check("bp_flush_id_exe", flush_id_exe, 0);

    // Two fetches outstanding, then branch
    @(negedge clk); idle(); if_req_fire = 1; #1;
    check("of_fetch_en0", fetch_en, 1);
    @(negedge clk); idle(); if_req_fire = 1; #1;
    @(negedge clk); idle();
    exe_valid = 1; br_req = 1; br_target = 64'h8000_0100; #1;
    check("br_flush_if_id", flush_if_id, 1);
    check("br_flush_id_exe", flush_id_exe, 1);
    check("br_flush_exe_mem", flush_exe_mem, 0);
    check("br_redirect", redirect_valid, 0);

    // Draining: branch ignored, responses discarded
    @(negedge clk); idle();
    if_resp_fire = 1; exe_valid = 1; br_req = 1; br_target = 64'h1234; #1;
    check("dr_discard1", resp_discard, 1);
    check("dr_fetch_en", fetch_en, 0);
    check("dr_if_allow", if_allow_in, 0);
    check("dr_br_ignored", flush_if_id, 0);
    check("dr_redirect1", redirect_valid, 0);
    @(negedge clk); idle(); if_resp_fire = 1; #1;
    check("dr_discard2", resp_discard, 1);
    check("dr_redirect2", redirect_valid, 0);
    @(negedge clk); idle(); #1;
    check("br_redir_valid", redirect_valid, 1);
    check("br_redir_pc", redirect_pc, 64'h8000_0100);
    check("br_redir_fetch_en", fetch_en, 0);
    // Spurious response at zero outstanding
    @(negedge clk); idle(); if_resp_fire = 1; #1;
    check("br_redir_single", redirect_valid, 0);
    check("spur_discard", resp_discard, 0);
    check("post_fetch_en", fetch_en, 1);

    // Fill to max outstanding
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); if_req_fire = 1; #1;
      check("fill_fetch_en", fetch_en, 1);
    end
    @(negedge clk); idle(); if_req_fire = 1; if_resp_fire = 1; #1;
    check("full_fetch_en", fetch_en, 0);
    check("full_run_discard", resp_discard, 0);
    @(negedge clk); idle(); #1;
    check("both_fire_unchanged", fetch_en, 0);
    @(negedge clk); idle(); if_resp_fire = 1; #1;
    @(negedge clk); idle(); if_resp_fire = 1; #1;
    check("dec_fetch_en", fetch_en, 1);
    @(negedge clk); idle(); if_resp_fire = 1; #1;

    // Trap and branch together: trap wins
    @(negedge clk); idle();
    mem_valid = 1; trap_req = 1; trap_target = 64'h8000_0000;
    exe_valid = 1; br_req = 1; br_target = 64'h8000_0100; #1;
    check("tb_flush_if_id", flush_if_id, 1);
    check("tb_flush_id_exe", flush_id_exe, 1);
    check("tb_flush_exe_mem", flush_exe_mem, 1);
    @(negedge clk); idle(); #1;
    check("tb_redirect_early", redirect_valid, 0);
    @(negedge clk); idle(); #1;
    check("tb_redirect", redirect_valid, 1);
    check("tb_redirect_pc", redirect_pc, 64'h8000_0000);
    @(negedge clk); idle(); #1;
    check("tb_redirect_end", redirect_valid, 0);

    // Branch, then trap while draining
    @(negedge clk); idle(); if_req_fire = 1; #1;
    @(negedge clk); idle(); exe_valid = 1; br_req = 1; br_target = 64'h8000_0100; #1;
    check("bt_br_flush_exe_mem", flush_exe_mem, 0);
    @(negedge clk); idle(); mem_valid = 1; trap_req = 1; trap_target = 64'h8000_0200; #1;
    check("bt_flush_if_id", flush_if_id, 1);
    check("bt_flush_id_exe", flush_id_exe, 1);
    check("bt_flush_exe_mem", flush_exe_mem, 1);
    check("bt_fetch_en", fetch_en, 0);
    @(negedge clk); idle(); if_resp_fire = 1; #1;
    check("bt_discard", resp_discard, 1);
    check("bt_redirect_early", redirect_valid, 0);
    @(negedge clk); idle(); #1;
    check("bt_redirect", redirect_valid, 1);
    check("bt_redirect_pc", redirect_pc, 64'h8000_0200);
    @(negedge clk); idle(); #1;
    check("bt_redirect_single", redirect_valid, 0);

    // Reset in the middle of a drain
    @(negedge clk); idle(); if_req_fire = 1;
    @(negedge clk); idle(); if_req_fire = 1;
    @(negedge clk); idle(); exe_valid = 1; br_req = 1; br_target = 64'h8000_0300;
    @(negedge clk); idle(); rst = 1; if_resp_fire = 1; #1;
    check("mr_rst_discard", resp_discard, 0);
    check("mr_rst_fetch_en", fetch_en, 0);
    @(negedge clk); idle(); rst = 0; #1;
    check("mr_fetch_en", fetch_en, 1);
    check("mr_redirect", redirect_valid, 0);
    check("mr_tgt", redirect_pc, 0);
`ifdef PIPE_CTRL_PERF_EN
    check("mr_perf_hazard", perf_hazard, 0);
    check("mr_perf_mem", perf_mem, 0);
    check("mr_perf_redirect", perf_redirect, 0);
`endif
    @(negedge clk); idle(); if_resp_fire = 1; #1;
    check("mr_stale_discard", resp_discard, 0);
    check("mr_redirect2", redirect_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); if_req_fire = 1; #1;
      check("mr_cnt_fetch_en", fetch_en, 1);
    end
    @(negedge clk); idle(); #1;
    check("mr_cnt_full", fetch_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
